// File: rtl/bcd_pkg.sv
//------------------------------------------------------------------------------
// bcd_pkg : shared constants, FSM encoding and limit helper for the BCD converter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Largest value representable in 'digits' decimal digits (10^digits - 1).
  function automatic int unsigned bcd_limit(input int unsigned digits);
    int unsigned lim;
    lim = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      lim = lim * 10;
    end
    return lim - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
//------------------------------------------------------------------------------
// bcd_digit_adjust : combinational double-dabble digit correction (+3 when >= 5)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] digit_out
);

  // Inputs are always 0..9, so the sum peaks at 12 and never carries out.
  assign digit_out = (digit_in >= ADJ_THRESH) ? digit_in + ADJ_ADD : digit_in;

endmodule

`default_nettype wire

// File: rtl/binary_to_bcd_converter.sv
//------------------------------------------------------------------------------
// binary_to_bcd_converter : sequential double-dabble binary to packed-BCD converter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module binary_to_bcd_converter
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [BIN_WIDTH-1:0]   bin_in,
  output logic                   busy,
  output logic                   done,
  output logic [4*DIGITS-1:0]    bcd_out,
  output logic                   overflow
);

  localparam int          BCD_W   = DIGIT_W * DIGITS;
  localparam int          SR_W    = BCD_W + BIN_WIDTH;
  localparam int          CNT_W   = $clog2(BIN_WIDTH + 1);
  localparam int unsigned C_LIMIT = bcd_limit(DIGITS);

  state_t             r_state;
  state_t             w_next;
  logic [SR_W-1:0]    r_shift;
  logic [CNT_W-1:0]   r_count;
  logic [BCD_W-1:0]   w_adj_bcd;
  logic [SR_W-1:0]    w_shifted;
  logic               w_over;
  logic               w_last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_adjust u_adj (
      .digit_in  (r_shift[BIN_WIDTH + DIGIT_W*g +: DIGIT_W]),
      .digit_out (w_adj_bcd[DIGIT_W*g +: DIGIT_W])
    );
  end

  assign w_shifted = {w_adj_bcd, r_shift[BIN_WIDTH-1:0]} << 1;
  assign w_over    = (32'(bin_in) > C_LIMIT);
  assign w_last    = (r_count == CNT_W'(BIN_WIDTH - 1));

  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_over ? DONE : SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Results (bcd_out, overflow) only move on the edge entering DONE so the
  // downstream display never sees a half-finished or stale flag combination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift  <= '0;
      r_count  <= '0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_over) begin
              bcd_out  <= {DIGITS{4'h9}};
              overflow <= 1'b1;
            end else begin
              r_shift <= {{BCD_W{1'b0}}, bin_in};
              r_count <= '0;
            end
          end
        end
        SHIFT: begin
          r_shift <= w_shifted;
          r_count <= r_count + 1'b1;
          if (w_last) begin
            bcd_out  <= w_shifted[BIN_WIDTH +: BCD_W];
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_binary_to_bcd_converter.sv
//------------------------------------------------------------------------------
// tb_binary_to_bcd_converter : scoreboard bench for the binary to BCD converter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_binary_to_bcd_converter;

  localparam int BIN_WIDTH = 14;
  localparam int DIGITS    = 4;
  localparam int LAT       = 14;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          k0;
    int          lat;
  } sb_entry_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [BIN_WIDTH-1:0] bin_in = '0;
  logic                 busy;
  logic                 done;
  logic [15:0]          bcd_out;
  logic                 overflow;

  sb_entry_t sb[$];
  int        cyc = 0;
  int        n_checks = 0;
  int        n_fail = 0;

  binary_to_bcd_converter #(.BIN_WIDTH(BIN_WIDTH), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic push(input int v);
    sb_entry_t e;
    if (v > 9999) begin
      e.bcd = 16'h9999; e.ovf = 1'b1; e.lat = 0;
    end else begin
      e.bcd = to_bcd(v); e.ovf = 1'b0; e.lat = LAT;
    end
    e.k0 = cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 64) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  // Pulses start for one accepted edge; caller guarantees the DUT is idle.
  task automatic convert(input int v, input bit wait_done);
    @(posedge clk); #1;
    bin_in = 14'(v);
    start  = 1'b1;
    @(posedge clk); #1;
    push(v);
    start = 1'b0;
    if (wait_done) drain();
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    int        busy_cycles;
    sb_entry_t e;
    busy_cycles = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cycles = 0;
      end else begin
        if (busy) busy_cycles++;
        if (done) begin
          if (sb.size() == 0) begin
            check("spurious_done", 32'(done), 0);
          end else begin
            e = sb.pop_front();
            check("bcd_out", 32'(bcd_out), 32'(e.bcd));
            check("overflow", 32'(overflow), 32'(e.ovf));
            check("latency", cyc - e.k0, e.lat);
            check("busy_cycles", busy_cycles, e.lat);
          end
          busy_cycles = 0;
        end
      end
    end
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation did not complete, %0d outstanding", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int vals[$];

    repeat (3) @(posedge clk);
    #1;
    check("rst_bcd", 32'(bcd_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ovf", 32'(overflow), 0);
    rst_n = 1'b1;

    convert(0, 1);
    convert(1234, 1);
    convert(9999, 1);
    convert(10000, 1);
    convert(42, 1);
    convert(16383, 1);
    convert(7, 1);

    // start and bin_in wiggled mid-conversion must not disturb the result
    convert(5678, 0);
    repeat (3) @(posedge clk);
    #1;
    bin_in = 14'd1;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain();
    repeat (20) @(posedge clk);
    #1;
    check("bcd_hold", 32'(bcd_out), 32'h5678);

    // asynchronous reset in the middle of a conversion
    convert(4321, 0);
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_bcd", 32'(bcd_out), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("post_abort_bcd", 32'(bcd_out), 0);
    convert(905, 1);

    // start held high: back-to-back conversions every BIN_WIDTH+2 cycles
    for (int i = 0; i < 50; i++) vals.push_back(i);
    for (int i = 9950; i < 10000; i++) vals.push_back(i);
    vals.push_back(500);
    vals.push_back(5000);
    vals.push_back(8888);
    for (int i = 0; i < 80; i++) vals.push_back(int'($urandom_range(0, 9999)));

    @(posedge clk); #1;
    bin_in = 14'(vals[0]);
    start  = 1'b1;
    for (int i = 0; i < vals.size(); i++) begin
      @(posedge clk); #1;
      push(vals[i]);
      bin_in = 14'($urandom);
      if (i == vals.size() - 1) begin
        start = 1'b0;
      end else begin
        repeat (LAT + 1) @(posedge clk);
        #1;
        bin_in = 14'(vals[i+1]);
      end
    end
    drain();
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
